alu_exec_stage: RTL and testbench

- Two-stage pipelined execute unit, directly downstream of the ALU control decoder.
- Consumes the decoder's 3-bit ALUControl plus the two operands and the destination register index; produces the ALU result and status flags.
- Uses valid/ready handshakes on both sides, so the core can stall or flush the execute path.
- Replaces the combinational ALU when the core runs pipelined.

---
 rtl/alu_exec_stage.sv | 155 +++++++++++++++
 tb/tb_alu_exec_stage.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_exec_stage.sv
// ============================================================================
// alu_exec_stage : two-stage pipelined ALU execute unit, valid/ready on both sides
// Rev 1.0
// ============================================================================
`default_nettype none

module alu_exec_stage #(
    parameter int WIDTH = 32,
    parameter int RD_W  = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       ALUControl,
    input  logic [WIDTH-1:0] SrcA,
    input  logic [WIDTH-1:0] SrcB,
    input  logic [RD_W-1:0]  RdIn,
    input  logic             flush,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] ALUResult,
    output logic             Zero,
    output logic             Negative,
    output logic             Carry,
    output logic             Overflow,
    output logic [RD_W-1:0]  RdOut,
    output logic             Illegal
);

    localparam int         MSB    = WIDTH - 1;
    localparam logic [2:0] OP_AND = 3'b000;
    localparam logic [2:0] OP_OR  = 3'b001;
    localparam logic [2:0] OP_ADD = 3'b010;
    localparam logic [2:0] OP_SUB = 3'b110;
    localparam logic [2:0] OP_SLT = 3'b111;

    logic             s1_valid_q;
    logic [2:0]       s1_ctrl_q;
    logic [WIDTH-1:0] s1_a_q;
    logic [WIDTH-1:0] s1_b_q;
    logic [RD_W-1:0]  s1_rd_q;

    logic             s2_valid_q;
    logic [WIDTH-1:0] result_q;
    logic             zero_q;
    logic             neg_q;
    logic             carry_q;
    logic             ovf_q;
    logic             illegal_q;
    logic [RD_W-1:0]  rd_q;

    logic             s2_adv;
    logic             s1_adv;
    logic [WIDTH:0]   sum;
    logic [WIDTH:0]   diff;
    logic [WIDTH-1:0] result_d;
    logic             carry_d;
    logic             ovf_d;
    logic             illegal_d;

    assign s2_adv   = !s2_valid_q || out_ready;
    assign s1_adv   = !s1_valid_q || s2_adv;
    assign in_ready = s1_adv;

    assign sum  = {1'b0, s1_a_q} + {1'b0, s1_b_q};
    assign diff = {1'b0, s1_a_q} - {1'b0, s1_b_q};

    // Unknown codes (including X/Z in simulation) fall through to default.
    always_comb begin
        result_d  = '0;
        carry_d   = 1'b0;
        ovf_d     = 1'b0;
        illegal_d = 1'b0;
        case (s1_ctrl_q)
            OP_ADD: begin
                result_d = sum[MSB:0];
                carry_d  = sum[WIDTH];
                ovf_d    = (s1_a_q[MSB] == s1_b_q[MSB]) && (sum[MSB] != s1_a_q[MSB]);
            end
            OP_SUB: begin
                result_d = diff[MSB:0];
                carry_d  = ~diff[WIDTH];
                ovf_d    = (s1_a_q[MSB] != s1_b_q[MSB]) && (diff[MSB] != s1_a_q[MSB]);
            end
            OP_AND:  result_d = s1_a_q & s1_b_q;
            OP_OR:   result_d = s1_a_q | s1_b_q;
            OP_SLT:  result_d = {{(WIDTH-1){1'b0}}, ($signed(s1_a_q) < $signed(s1_b_q))};
            default: illegal_d = 1'b1;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s1_valid_q <= 1'b0;
            s1_ctrl_q  <= '0;
            s1_a_q     <= '0;
            s1_b_q     <= '0;
            s1_rd_q    <= '0;
        end else begin
            if (flush) begin
                s1_valid_q <= 1'b0;
            end else if (s1_adv) begin
                s1_valid_q <= in_valid;
            end
            if (s1_adv && in_valid) begin
                s1_ctrl_q <= ALUControl;
                s1_a_q    <= SrcA;
                s1_b_q    <= SrcB;
                s1_rd_q   <= RdIn;
            end
        end
    end

    // Output data only changes when a real op moves in, so it holds while empty.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s2_valid_q <= 1'b0;
            result_q   <= '0;
            zero_q     <= 1'b1;
            neg_q      <= 1'b0;
            carry_q    <= 1'b0;
            ovf_q      <= 1'b0;
            illegal_q  <= 1'b0;
            rd_q       <= '0;
        end else begin
            if (flush) begin
                s2_valid_q <= 1'b0;
            end else if (s2_adv) begin
                s2_valid_q <= s1_valid_q;
            end
            if (s2_adv && s1_valid_q) begin
                result_q  <= result_d;
                zero_q    <= (result_d == '0);
                neg_q     <= result_d[MSB];
                carry_q   <= carry_d;
                ovf_q     <= ovf_d;
                illegal_q <= illegal_d;
                rd_q      <= s1_rd_q;
            end
        end
    end

    assign out_valid = s2_valid_q;
    assign ALUResult = result_q;
    assign Zero      = zero_q;
    assign Negative  = neg_q;
    assign Carry     = carry_q;
    assign Overflow  = ovf_q;
    assign Illegal   = illegal_q;
    assign RdOut     = rd_q;

endmodule

`default_nettype wire

// File: tb/tb_alu_exec_stage.sv
// ============================================================================
// tb_alu_exec_stage : directed self-checking bench for alu_exec_stage
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_alu_exec_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [2:0]  ALUControl;
    logic [31:0] SrcA;
    logic [31:0] SrcB;
    logic [4:0]  RdIn;
    logic        flush;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] ALUResult;
    logic        Zero;
    logic        Negative;
    logic        Carry;
    logic        Overflow;
    logic [4:0]  RdOut;
    logic        Illegal;

    int checks = 0;
    int errors = 0;

    alu_exec_stage #(.WIDTH(32), .RD_W(5)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .ALUControl (ALUControl),
        .SrcA       (SrcA),
        .SrcB       (SrcB),
        .RdIn       (RdIn),
        .flush      (flush),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .ALUResult  (ALUResult),
        .Zero       (Zero),
        .Negative   (Negative),
        .Carry      (Carry),
        .Overflow   (Overflow),
        .RdOut      (RdOut),
        .Illegal    (Illegal)
    );

    always #5 clk = ~clk;

    localparam logic [2:0] AND_OP = 3'b000;
    localparam logic [2:0] OR_OP  = 3'b001;
    localparam logic [2:0] ADD_OP = 3'b010;
    localparam logic [2:0] SUB_OP = 3'b110;
    localparam logic [2:0] SLT_OP = 3'b111;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic v, input logic [2:0] c, input logic [31:0] a,
                         input logic [31:0] b, input logic [4:0] rd);
        in_valid   = v;
        ALUControl = c;
        SrcA       = a;
        SrcB       = b;
        RdIn       = rd;
    endtask

    // Single op through an idle pipeline with out_ready=1: result visible 2 edges later.
    task automatic run_op(input logic [2:0] c, input logic [31:0] a,
                          input logic [31:0] b, input logic [4:0] rd);
        drive(1'b1, c, a, b, rd);
        tick();
        in_valid = 1'b0;
        tick();
    endtask

    task automatic chk_flags(input string tag, input logic z, input logic n,
                             input logic c, input logic o, input logic il);
        chk({tag, ".Zero"},     {31'd0, Zero},     {31'd0, z});
        chk({tag, ".Negative"}, {31'd0, Negative}, {31'd0, n});
        chk({tag, ".Carry"},    {31'd0, Carry},    {31'd0, c});
        chk({tag, ".Overflow"}, {31'd0, Overflow}, {31'd0, o});
        chk({tag, ".Illegal"},  {31'd0, Illegal},  {31'd0, il});
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst       = 1'b0;
        flush     = 1'b0;
        out_ready = 1'b1;
        drive(1'b0, 3'b000, 32'd0, 32'd0, 5'd0);

        // Reset state
        tick();
        tick();
        chk("rst.out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst.ALUResult", ALUResult, 32'd0);
        chk("rst.RdOut",     {27'd0, RdOut}, 32'd0);
        chk_flags("rst", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        rst = 1'b1;
        #1;
        chk("rst.in_ready", {31'd0, in_ready}, 32'd1);

        // ADD with signed overflow, 2-cycle latency
        drive(1'b1, ADD_OP, 32'h7FFF_FFFF, 32'h1, 5'd3);
        tick();
        in_valid = 1'b0;
        chk("add.lat1.out_valid", {31'd0, out_valid}, 32'd0);
        tick();
        chk("add.out_valid", {31'd0, out_valid}, 32'd1);
        chk("add.ALUResult", ALUResult, 32'h8000_0000);
        chk("add.RdOut", {27'd0, RdOut}, 32'd3);
        chk_flags("add", 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
        tick();

        // ADD with unsigned carry wrapping to zero
        run_op(ADD_OP, 32'hFFFF_FFFF, 32'h1, 5'd8);
        chk("addc.ALUResult", ALUResult, 32'h0);
        chk_flags("addc", 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        tick();

        // Back-to-back SUBs
        drive(1'b1, SUB_OP, 32'd5, 32'd5, 5'd1);
        tick();
        drive(1'b1, SUB_OP, 32'd3, 32'd5, 5'd2);
        tick();
        in_valid = 1'b0;
        chk("sub0.out_valid", {31'd0, out_valid}, 32'd1);
        chk("sub0.ALUResult", ALUResult, 32'h0);
        chk("sub0.RdOut", {27'd0, RdOut}, 32'd1);
        chk_flags("sub0", 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        tick();
        chk("sub1.out_valid", {31'd0, out_valid}, 32'd1);
        chk("sub1.ALUResult", ALUResult, 32'hFFFF_FFFE);
        chk("sub1.RdOut", {27'd0, RdOut}, 32'd2);
        chk_flags("sub1", 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        tick();
        chk("idle.out_valid", {31'd0, out_valid}, 32'd0);
        chk("idle.hold", ALUResult, 32'hFFFF_FFFE);

        // Logic ops and SLT
        run_op(AND_OP, 32'hF0F0_F0F0, 32'h0FF0_0FF0, 5'd10);
        chk("and.ALUResult", ALUResult, 32'h00F0_00F0);
        chk_flags("and", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        tick();
        run_op(OR_OP, 32'hF0F0_F0F0, 32'h0FF0_0FF0, 5'd11);
        chk("or.ALUResult", ALUResult, 32'hFFF0_FFF0);
        chk_flags("or", 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        tick();
        run_op(SLT_OP, 32'hFFFF_FFFE, 32'h1, 5'd12);
        chk("slt_lt.ALUResult", ALUResult, 32'h1);
        chk_flags("slt_lt", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        tick();
        run_op(SLT_OP, 32'h1, 32'hFFFF_FFFE, 5'd13);
        chk("slt_ge.ALUResult", ALUResult, 32'h0);
        chk_flags("slt_ge", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        tick();

        // Illegal opcode
        run_op(3'b011, 32'h1234_5678, 32'h1, 5'd14);
        chk("ill.ALUResult", ALUResult, 32'h0);
        chk("ill.RdOut", {27'd0, RdOut}, 32'd14);
        chk_flags("ill", 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
        tick();

        // Backpressure: 4-op stream, two held while out_ready=0
        out_ready = 1'b0;
        drive(1'b1, ADD_OP, 32'd1, 32'd2, 5'd4);
        tick();
        drive(1'b1, ADD_OP, 32'd10, 32'd20, 5'd5);
        tick();
        drive(1'b1, SUB_OP, 32'd100, 32'd1, 5'd6);
        chk("bp.in_ready_low", {31'd0, in_ready}, 32'd0);
        tick();
        tick();
        chk("bp.stall.out_valid", {31'd0, out_valid}, 32'd1);
        chk("bp.stall.ALUResult", ALUResult, 32'd3);
        chk("bp.stall.RdOut", {27'd0, RdOut}, 32'd4);
        chk("bp.stall.in_ready", {31'd0, in_ready}, 32'd0);
        out_ready = 1'b1;
        #1;
        chk("bp.release.in_ready", {31'd0, in_ready}, 32'd1);
        tick();
        chk("bp.op1.ALUResult", ALUResult, 32'd30);
        chk("bp.op1.RdOut", {27'd0, RdOut}, 32'd5);
        drive(1'b1, OR_OP, 32'hA, 32'h5, 5'd7);
        tick();
        in_valid = 1'b0;
        chk("bp.op2.ALUResult", ALUResult, 32'd99);
        chk("bp.op2.RdOut", {27'd0, RdOut}, 32'd6);
        tick();
        chk("bp.op3.ALUResult", ALUResult, 32'hF);
        chk("bp.op3.RdOut", {27'd0, RdOut}, 32'd7);
        chk("bp.op3.out_valid", {31'd0, out_valid}, 32'd1);
        tick();
        chk("bp.drain.out_valid", {31'd0, out_valid}, 32'd0);

        // Flush with two ops in flight and a new input presented
        drive(1'b1, ADD_OP, 32'd7, 32'd7, 5'd20);
        tick();
        drive(1'b1, ADD_OP, 32'd8, 32'd8, 5'd21);
        tick();
        out_ready = 1'b0;
        drive(1'b1, ADD_OP, 32'd9, 32'd9, 5'd22);
        flush = 1'b1;
        tick();
        flush     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        chk("flush.out_valid0", {31'd0, out_valid}, 32'd0);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("flush.out_valid", {31'd0, out_valid}, 32'd0);
        end

        // Flush discards an input even when in_ready=1
        drive(1'b1, ADD_OP, 32'd1, 32'd1, 5'd23);
        flush = 1'b1;
        #1;
        chk("flush2.in_ready", {31'd0, in_ready}, 32'd1);
        tick();
        flush    = 1'b0;
        in_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("flush2.out_valid", {31'd0, out_valid}, 32'd0);
        end

        // Asynchronous reset mid-stall
        out_ready = 1'b0;
        drive(1'b1, ADD_OP, 32'd5, 32'd5, 5'd9);
        tick();
        drive(1'b1, ADD_OP, 32'd6, 32'd6, 5'd10);
        tick();
        in_valid = 1'b0;
        chk("stall.ALUResult", ALUResult, 32'd10);
        chk("stall.out_valid", {31'd0, out_valid}, 32'd1);
        #2;
        rst = 1'b0;
        #1;
        chk("arst.out_valid", {31'd0, out_valid}, 32'd0);
        chk("arst.ALUResult", ALUResult, 32'd0);
        chk("arst.RdOut", {27'd0, RdOut}, 32'd0);
        chk_flags("arst", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        tick();
        rst = 1'b1;
        #1;
        chk("arst.in_ready", {31'd0, in_ready}, 32'd1);
        for (int i = 0; i < 2; i++) begin
            tick();
            chk("arst.empty.out_valid", {31'd0, out_valid}, 32'd0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
